// File: rtl/alu_pkg.sv
// ALU control shared definitions: ALU op codes, ALUOp classes and funct3 values.
// Imported by the ALU control block and by the ALU datapath.
package alu_pkg;

    // 4-bit ALU operation codes; 1010-1111 are never produced
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLTU = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;

    // Instruction class presented by the main decoder
    localparam logic [1:0] ALUOP_MEM    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

    // funct3 values for the integer ALU group
    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

endpackage

// File: rtl/alu_funct_decode.sv
// Combinational funct3/funct7 decode to an ALU op code.
// Ports: funct7_5, funct3, is_itype in; op out.
module alu_funct_decode
    import alu_pkg::*;
(
    input  logic       funct7_5,
    input  logic [2:0] funct3,
    input  logic       is_itype,
    output logic [3:0] op
);

    always_comb begin
        op = ALU_ADD;
        unique case (funct3)
            // I-type add has immediate bits in funct7, so no SUB form
            F3_ADD_SUB: op = (funct7_5 && !is_itype) ? ALU_SUB : ALU_ADD;
            F3_SLL:     op = ALU_SLL;
            F3_SLT:     op = ALU_SLT;
            F3_SLTU:    op = ALU_SLTU;
            F3_XOR:     op = ALU_XOR;
            F3_SRL_SRA: op = funct7_5 ? ALU_SRA : ALU_SRL;
            F3_OR:      op = ALU_OR;
            F3_AND:     op = ALU_AND;
            default:    op = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/alu_control.sv
// ALU control: selects the ALU op from ALUOp/funct fields and registers it.
// Ports: i_clk, i_rst_n (sync, low), i_Funct7, i_Funct3, i_ALUOp in; o_ALUControlLines out.
module alu_control
    import alu_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [6:0] i_Funct7,
    input  logic [2:0] i_Funct3,
    input  logic [1:0] i_ALUOp,
    output logic [3:0] o_ALUControlLines
);

    logic [3:0] funct_op;
    logic [3:0] next_op;

    alu_funct_decode u_decode (
        .funct7_5 (i_Funct7[5]),
        .funct3   (i_Funct3),
        .is_itype (i_ALUOp == ALUOP_ITYPE),
        .op       (funct_op)
    );

    // Memory and branch classes pick a constant, so funct fields
    // (possibly unknown there) never reach the register.
    always_comb begin
        next_op = ALU_ADD;
        unique case (i_ALUOp)
            ALUOP_MEM:    next_op = ALU_ADD;
            ALUOP_BRANCH: next_op = ALU_SUB;
            ALUOP_RTYPE:  next_op = funct_op;
            ALUOP_ITYPE:  next_op = funct_op;
            default:      next_op = ALU_ADD;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_ALUControlLines <= ALU_ADD;
        end else begin
            o_ALUControlLines <= next_op;
        end
    end

endmodule

// File: tb/tb_alu_control.sv
// Self-checking bench for alu_control: directed cases plus random stimulus
// against a table-based reference model.
module tb_alu_control;

    logic       clk;
    logic       rst_n;
    logic [6:0] funct7;
    logic [2:0] funct3;
    logic [1:0] alu_op;
    logic [3:0] ctrl;

    int n_tests;
    int n_fail;
    logic [3:0] cur_exp;
    bit         exp_valid;

    alu_control dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .i_Funct7          (funct7),
        .i_Funct3          (funct3),
        .i_ALUOp           (alu_op),
        .o_ALUControlLines (ctrl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %b, want %b", tag, got, want);
        end
    endtask

    // Reference: R-type funct3 table, with funct7[5] selecting the
    // alternate op for add/sub and srl/sra.
    function automatic logic [3:0] ref_op(input logic [1:0] op, input logic [2:0] f3,
                                          input logic [6:0] f7, input logic rst);
        logic [3:0] base [8];
        base = '{4'd2, 4'd4, 4'd7, 4'd8, 4'd3, 4'd5, 4'd1, 4'd0};
        if (!rst) return 4'd2;
        if (op == 2'd0) return 4'd2;
        if (op == 2'd1) return 4'd6;
        if (f7[5] && f3 == 3'd5) return 4'd9;
        if (f7[5] && f3 == 3'd0 && op == 2'd2) return 4'd6;
        return base[f3];
    endfunction

    // Called just after a falling edge. Drives junk first, checks the
    // output holds, then drives the real values ahead of the rising edge.
    task automatic step(input string tag, input logic [1:0] op, input logic [2:0] f3,
                        input logic [6:0] f7, input logic rst);
        alu_op = 2'($urandom);
        funct3 = 3'($urandom);
        funct7 = 7'($urandom);
        rst_n  = 1'($urandom);
        #1;
        if (exp_valid) check({tag, "_hold"}, ctrl, cur_exp);
        #1;
        alu_op = op;
        funct3 = f3;
        funct7 = f7;
        rst_n  = rst;
        @(posedge clk);
        #1;
        alu_op = 2'($urandom);
        funct3 = 3'($urandom);
        funct7 = 7'($urandom);
        @(negedge clk);
        cur_exp   = ref_op(op, f3, f7, rst);
        exp_valid = 1'b1;
        check(tag, ctrl, cur_exp);
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        exp_valid = 1'b0;
        cur_exp   = 4'd0;
        rst_n     = 1'b0;
        alu_op    = 2'd2;
        funct3    = 3'd7;
        funct7    = 7'd0;
        @(negedge clk);

        // Reset held for two edges with an AND decode pending
        step("rst0", 2'd2, 3'd7, 7'd0, 1'b0);
        check("rst0_val", ctrl, 4'b0010);
        step("rst1", 2'd2, 3'd7, 7'd0, 1'b0);
        step("rst_rel", 2'd2, 3'd7, 7'd0, 1'b1);
        check("rst_rel_val", ctrl, 4'b0000);

        // Sweeps with funct7 = 0 and 32
        for (int s = 0; s < 2; s++) begin
            for (int o = 0; o < 3; o++) begin
                for (int f = 0; f < 8; f++) begin
                    step($sformatf("sw%0d_op%0d_f%0d", s, o, f),
                         2'(o), 3'(f), (s == 1) ? 7'd32 : 7'd0, 1'b1);
                end
            end
        end

        // I-type cases with literal expectations
        step("i_add", 2'd3, 3'd0, 7'd32, 1'b1);
        check("i_add_lit", ctrl, 4'b0010);
        step("i_sra", 2'd3, 3'd5, 7'd32, 1'b1);
        check("i_sra_lit", ctrl, 4'b1001);
        step("i_srl", 2'd3, 3'd5, 7'd0, 1'b1);
        check("i_srl_lit", ctrl, 4'b0101);

        // Only funct7[5] matters
        step("mask_add", 2'd2, 3'd0, 7'b1011111, 1'b1);
        check("mask_add_lit", ctrl, 4'b0010);
        step("mask_sub", 2'd2, 3'd0, 7'b0100000, 1'b1);
        check("mask_sub_lit", ctrl, 4'b0110);

        // Mid-stream reset discards the OR decode
        step("mid_rst", 2'd2, 3'd6, 7'd0, 1'b0);
        check("mid_rst_lit", ctrl, 4'b0010);
        step("mid_rel", 2'd2, 3'd6, 7'd0, 1'b1);
        check("mid_rel_lit", ctrl, 4'b0001);

        // Random traffic, reset asserted occasionally
        for (int i = 0; i < 300; i++) begin
            step($sformatf("rnd%0d", i), 2'($urandom), 3'($urandom), 7'($urandom),
                 ($urandom_range(0, 15) != 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
